stopwatch_seq_ctrl: RTL
=======================

// Module: stopwatch_seq_ctrl
// PURPOSE
//  Run/pause/clear controller for the stopwatch time chain, MM:SS.hh format.
//  Owns the prescaler and the run-state FSM.
//  Sequences six BCD digit cells in the order hh0 hh1 s0 s1 m0 m1.
//  Each cell uses an increment-and-wrap datapath with modulus 10 or 6, and each carry enables the next cell.
//  Sits between debounced push-button pulses and the 7-segment display driver.
// PARAMETERS
//  PRESCALE   500000   clk cycles per 1/100 s (50 MHz -> 100 Hz); legal range >= 2
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  start_stop  in   1   1-cycle pulse: toggles run/pause
//  clr         in   1   1-cycle pulse: stop and zero all digits
//  alarm_time  in   16  BCD {m1,m0,s1,s0}; used only with ALARM_EN
//  digits      out  24  BCD {m1,m0,s1,s0,hh1,hh0}, 4 bits each
//  running     out  1   high while FSM in RUN
//  rollover    out  1   1-cycle pulse on wrap 59:59.99 -> 00:00.00
//  alarm       out  1   sticky alarm flag; ALARM_EN only, else tied 0
// BEHAVIOUR
//  Reset: state=IDLE; digits=0; prescaler=0; running=0; rollover=0; alarm=0.
//  FSM states: IDLE, RUN, PAUSE.
//   IDLE  --start_stop--> RUN
//   RUN   --start_stop--> PAUSE
//   PAUSE --start_stop--> RUN
//   any   --clr--> IDLE
//  clr and start_stop in the same cycle: clr wins; next state is IDLE.
//  Entering IDLE: digits and prescaler zero on the same edge that registers the state.
//  Prescaler:
//   - counts 0..PRESCALE-1 only in RUN; holds its value in PAUSE (resume is mid-interval); zero in IDLE.
//   - tick=1 for one cycle when prescaler==PRESCALE-1 in RUN; prescaler then returns to 0.
//  Latency: start_stop sampled at edge N -> running=1 after N; first hh0 increment PRESCALE cycles later.
//  Digit update:
//   - hh0 increments on tick.
//   - cell k increments when cell k-1 wraps in that same cycle; all six update on one edge (no ripple delay).
//   - moduli: hh0=10, hh1=10, s0=10, s1=6, m0=10, m1=6.
//   - a cell wraps to 0 at modulus-1; carry_out = en & (val==modulus-1).
//   - digit values never exceed modulus-1.
//  Full-chain wrap: rollover=1 for exactly one cycle; RUN continues, no stop.
//  start_stop on the tick cycle: that increment still occurs, then the FSM enters PAUSE.
//  Reset asserted mid-count: immediate return to reset values; no partial update.
// CONFIGURATION
//  Macro STOPWATCH_ALARM_EN; exactly one feature is optional.
//  Defined:
//   - on a digit-update edge where the new {m1,m0,s1,s0}==alarm_time and new hh1:hh0==00, alarm sets.
//   - alarm stays set until clr or the next start_stop pulse.
//   - match in PAUSE or IDLE does not set the flag.
//  Undefined: alarm tied 0; alarm_time unused (port kept for a stable interface); no compare logic.
// STRUCTURE
//  Package stopwatch_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;
//   - localparams MOD10=4'd10 and MOD6=4'd6;
//   - typedef logic [3:0] bcd_t.
//  Sub-module bcd_digit_cell:
//   - param MOD; ports clk, rst_n, clr, en, val[3:0], carry.
//   - instantiated six times in a chain.
//  Top holds the FSM, prescaler, rollover/alarm logic.
// TESTING  (bench overrides PRESCALE=2)
//  1 Reset then idle 20 cycles -> digits=0, running=0, rollover=0, alarm=0.
//  2 start_stop, run 2*10 cycles -> digits=24'h000010 (0.10 s); hh0 wrapped 9->0, hh1=1.
//  3 Preload via run to 00:59.99, one more tick:
//     -> digits=24'h010000 (01:00.00), with s1 wrapping modulo 6, not 10.
//  4 Run to 59:59.99, one tick:
//     -> digits=0; rollover high exactly 1 cycle; running stays 1.
//  5 Pause at prescaler=1, wait 50 cycles:
//     -> digits frozen; resume -> next increment after 1 cycle.
//     Then clr+start_stop in the same cycle -> IDLE, digits=0.
//  6 (STOPWATCH_ALARM_EN) alarm_time=16'h0001, run:
//     -> alarm rises on the edge digits become 24'h000100 and stays high.
//     start_stop -> alarm=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch time chain (MM:SS.hh, BCD digits).
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MOD10 = 4'd10;
    localparam bcd_t MOD6  = 4'd6;

    // Increment with wrap to 0 at modulus-1.
    function automatic bcd_t bcd_next(input bcd_t val, input bcd_t modulus);
        if (val == modulus - 4'd1) begin
            return '0;
        end
        return val + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the stopwatch chain: increments on en, wraps at MOD-1 and
// raises carry in the same cycle so the whole chain updates on a single edge.
module bcd_digit_cell
    import stopwatch_pkg::*;
#(
    parameter bcd_t MOD = MOD10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] val,
    output logic       carry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
        end else if (clr) begin
            val <= '0;
        end else if (en) begin
            val <= bcd_next(val, MOD);
        end
    end

    assign carry = en & (val == MOD - 4'd1);

endmodule

// File: rtl/stopwatch_seq_ctrl.sv
// Run/pause/clear controller for the MM:SS.hh stopwatch: FSM, 1/100 s prescaler,
// six-digit BCD chain and rollover pulse. Optional alarm via STOPWATCH_ALARM_EN.
//
// state | meaning
// IDLE  | stopped, digits and prescaler held at zero
// RUN   | prescaler counting, digits advance on each tick
// PAUSE | prescaler and digits frozen, resume continues mid-interval
module stopwatch_seq_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned PRESCALE = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clr,
    input  logic [15:0] alarm_time,
    output logic [23:0] digits,
    output logic        running,
    output logic        rollover,
    output logic        alarm
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    sw_state_t     state, state_nxt;
    logic [PW-1:0] presc;
    logic          tick;
    logic          zero;

    bcd_t v_hh0, v_hh1, v_s0, v_s1, v_m0, v_m1;
    logic c_hh0, c_hh1, c_s0, c_s1, c_m0, c_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Zeroing keys off the next state so digits clear on the edge that enters IDLE.
    assign zero    = (state_nxt == IDLE);
    assign running = (state == RUN);
    assign tick    = (state == RUN) && (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (zero) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    bcd_digit_cell #(.MOD(MOD10)) u_hh0 (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(tick),  .val(v_hh0), .carry(c_hh0)
    );
    bcd_digit_cell #(.MOD(MOD10)) u_hh1 (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(c_hh0), .val(v_hh1), .carry(c_hh1)
    );
    bcd_digit_cell #(.MOD(MOD10)) u_s0 (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(c_hh1), .val(v_s0),  .carry(c_s0)
    );
    bcd_digit_cell #(.MOD(MOD6)) u_s1 (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(c_s0),  .val(v_s1),  .carry(c_s1)
    );
    bcd_digit_cell #(.MOD(MOD10)) u_m0 (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(c_s1),  .val(v_m0),  .carry(c_m0)
    );
    bcd_digit_cell #(.MOD(MOD6)) u_m1 (
        .clk(clk), .rst_n(rst_n), .clr(zero), .en(c_m0),  .val(v_m1),  .carry(c_m1)
    );

    assign digits = {v_m1, v_m0, v_s1, v_s0, v_hh1, v_hh0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rollover <= 1'b0;
        end else if (zero) begin
            rollover <= 1'b0;
        end else begin
            rollover <= c_m1;
        end
    end

`ifdef STOPWATCH_ALARM_EN
    logic [15:0] time_nxt;
    logic [7:0]  hund_nxt;

    // Compare against the values the chain is about to load, so the flag rises with the digits.
    assign time_nxt = {c_m0  ? bcd_next(v_m1, MOD6)   : v_m1,
                       c_s1  ? bcd_next(v_m0, MOD10)  : v_m0,
                       c_s0  ? bcd_next(v_s1, MOD6)   : v_s1,
                       c_hh1 ? bcd_next(v_s0, MOD10)  : v_s0};
    assign hund_nxt = {c_hh0 ? bcd_next(v_hh1, MOD10) : v_hh1,
                       tick  ? bcd_next(v_hh0, MOD10) : v_hh0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= 1'b0;
        end else if (clr || start_stop) begin
            alarm <= 1'b0;
        end else if (tick && (time_nxt == alarm_time) && (hund_nxt == 8'h00)) begin
            alarm <= 1'b1;
        end
    end
`else
    logic unused_alarm_time;
    assign unused_alarm_time = ^alarm_time;
    assign alarm = 1'b0;
`endif

endmodule
